// File: rtl/ks_stream_buffer_pkg.sv
// Shared ChaCha20 keystream types: state word, 4x4 block matrix, and the
// block-to-byte flattening in RFC 8439 little-endian order.
package ks_stream_buffer_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [3:0][3:0] matrix_t;

  localparam int BLOCK_BYTES = 64;

  typedef logic [BLOCK_BYTES-1:0][7:0] block_bytes_t;

  // Byte b comes from word k=b/4 (k=row*4+col), least significant byte first.
  function automatic block_bytes_t block_to_bytes(input matrix_t m);
    block_bytes_t b;
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 4; j++) begin
        b[4*k+j] = m[k/4][k%4][8*j +: 8];
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/ks_stream_buffer_unpack.sv
// Combinational ChaCha20 matrix to 64-byte flattener, shared with the MAC key path.
module ks_block_unpack
  import ks_stream_buffer_pkg::*;
(
  input  matrix_t      blk_i,
  output block_bytes_t bytes_o
);

  assign bytes_o = block_to_bytes(blk_i);

endmodule

// File: rtl/ks_stream_buffer.sv
// Keystream buffer: accepts whole 64-byte ChaCha20 blocks into a circular byte
// store and streams OUT_BYTES-wide beats to the XOR/Poly1305 datapath.
module ks_stream_buffer
  import ks_stream_buffer_pkg::*;
#(
  parameter int NUM_MATRICES = 2,
  parameter int OUT_BYTES    = 8,
  parameter int DATA_SIZE    = 8,
  parameter int NO_REG       = BLOCK_BYTES * NUM_MATRICES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  matrix_t                       indata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [8*OUT_BYTES-1:0]        out_data,
  output logic                          out_last,
  output logic [$clog2(NO_REG+1)-1:0]   level,
  output logic                          full,
  output logic                          empty
);

  localparam int PW = $clog2(NO_REG);
  localparam int LW = $clog2(NO_REG + 1);

  if (DATA_SIZE != 8) begin : g_bad_data_size
    $error("ks_stream_buffer: DATA_SIZE must be 8");
  end
  if ((BLOCK_BYTES % OUT_BYTES) != 0) begin : g_bad_out_bytes
    $error("ks_stream_buffer: OUT_BYTES must divide 64");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    mem_q [NO_REG];
  block_bytes_t  blk_bytes;
  logic          wr_en, rd_en;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int unsigned inc);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(inc);
    if (s >= (PW+1)'(NO_REG)) s = s - (PW+1)'(NO_REG);
    return s[PW-1:0];
  endfunction

  ks_block_unpack u_unpack (
    .blk_i   (indata),
    .bytes_o (blk_bytes)
  );

  // Handshake readiness depends on the registered level only.
  assign in_ready  = (level_q <= LW'(NO_REG - BLOCK_BYTES));
  assign out_valid = (level_q >= LW'(OUT_BYTES));
  assign wr_en     = in_valid && in_ready && !flush;
  assign rd_en     = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = ptr_add(wr_ptr_q, BLOCK_BYTES);
      if (rd_en) rd_ptr_d = ptr_add(rd_ptr_q, OUT_BYTES);
      level_d = level_q + (wr_en ? LW'(BLOCK_BYTES) : '0) - (rd_en ? LW'(OUT_BYTES) : '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Store contents are deliberately unreset; level gates all visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BLOCK_BYTES; i++) begin
        mem_q[wr_ptr_q + PW'(i)] <= blk_bytes[i];
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int i = 0; i < OUT_BYTES; i++) begin
        out_data[8*i +: 8] = mem_q[rd_ptr_q + PW'(i)];
      end
    end
  end

  assign out_last = out_valid && (rd_ptr_q[5:0] == 6'(BLOCK_BYTES - OUT_BYTES));
  assign level    = level_q;
  assign full     = (level_q == LW'(NO_REG));
  assign empty    = (level_q == '0);

  ast_level_bound: assert property (@(posedge clk) disable iff (!rst)
    level_q <= LW'(NO_REG));
  ast_write_space: assert property (@(posedge clk) disable iff (!rst)
    wr_en |-> (level_q <= LW'(NO_REG - BLOCK_BYTES)));

endmodule
